alu_hs: RTL and testbench
=========================

Name: alu_hs

Overview:
- Parametrised N-bit successor to the single-cycle datapath ALU.
- Adds a valid/ready handshake on both sides, a registered result, and NZCV flags.
- Adds an illegal-opcode flag and a multi-cycle iterative multiply.
- Sits between the operand/issue stage and writeback. It is the first ALU that can stall the pipeline.

Parameters:
N, 64, operand/result width; must be ≥ 8 and a multiple of MUL_STEP.
MUL_STEP, 1, multiplier bits retired per BUSY cycle; legal values 1, 2, 4.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
a  in  N  operand A
b  in  N  operand B
ALUControl  in  4  opcode
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer takes the result this cycle
result  out  N  registered result
zero  out  1  result == 0
negative  out  1  result[N-1]
carry  out  1  carry out (ADD); NOT borrow (SUB); 0 otherwise
overflow  out  1  signed overflow (ADD/SUB); unsigned product overflow (MUL); 0 otherwise
illegal  out  1  opcode was not in the table below

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_valid=0; result=0; zero=1; negative=carry=overflow=illegal=0; multiply counter=0.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a-b)
  - 0111 PASS b
  - 1100 NOR
  - 1000 MUL: low N bits of unsigned a*b
  - any other code: result=0, zero=1, illegal=1, all other flags 0.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge. Inputs are sampled only on that edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is purely combinational from state and out_ready.
- States:
  - IDLE → HOLD on accepting a single-cycle op. Result and flags are registered on that edge, and out_valid=1 the next cycle (latency 1).
  - IDLE → BUSY on accepting MUL. Load multiplicand=a, multiplier=b, accumulator=0, counter=0. Result outputs keep their old values.
  - BUSY: each cycle, accumulator += (multiplicand × multiplier low MUL_STEP bits); multiplicand <<= MUL_STEP; multiplier >>= MUL_STEP; counter++.
  - BUSY → HOLD on the cycle counter reaches N/MUL_STEP-1. MUL latency from accept to out_valid = N/MUL_STEP + 1 cycles.
  - BUSY: in_ready=0 and in_valid is ignored.
  - HOLD: out_valid=1. result and flags are stable until consumed.
  - HOLD with out_ready=0 → stay in HOLD.
  - HOLD with out_ready=1 and no new accept → IDLE; out_valid=0 next cycle. result keeps its last value.
  - HOLD with out_ready=1 and a simultaneous accept → behaves as an accept from IDLE (back-to-back). Single-cycle ops sustain 1 op/cycle.
- Arithmetic: ADD/SUB use an N+1-bit sum; SUB = a + ~b + 1.
  - carry = bit N of that sum.
  - overflow = operand signs equal (after inverting b for SUB) and result sign differs.
- MUL overflow: any bit set in the upper N bits of the 2N-bit product. The accumulator is 2N bits wide internally.
- zero and negative are computed from the registered result for every opcode.
- Reset asserted mid-BUSY or mid-HOLD: the operation is discarded and all outputs take their reset values. No partial result is ever presented.
- No X on any output after reset, regardless of inputs.

Test Plan:
- AND a=0xabcde, b=0xef8965 → one cycle after accept: out_valid=1, result=0xa8844, zero=0, carry=0, overflow=0.
- ADD a=0x12345678, b=0x75abef → result=0x12aa0267, C=0, V=0. Then SUB a=0x8000_0000_0000_0000, b=1 → result=0x7fff_ffff_ffff_ffff, C=1, V=1, N=0.
- MUL a=0x12345, b=0x10, N=64, MUL_STEP=1:
  - in_ready=0 for 64 cycles; out_valid on cycle 65; result=0x123450, V=0.
  - Repeat with a=b=0x1_0000_0000 → result=0, zero=1, V=1.
  - Repeat with MUL_STEP=4 → out_valid on cycle 17 with identical values.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and result unchanged throughout. Raise out_ready → result consumed and next op accepted on the same edge. Next result appears on the following cycle.
- Opcode 0011, a=0x99999, b=0xaaaa → result=0, zero=1, illegal=1. A following PASS b=0xbaba6767 clears illegal and gives result=0xbaba6767.
- Deassert reset for 1 cycle during BUSY (cycle 10 of MUL) → asynchronously: out_valid=0, in_ready=0, result=0, zero=1. After release: in_ready=1 and the next op completes normally.

Source files
------------

// File: rtl/alu_hs.sv
// alu_hs: N-bit ALU with valid/ready handshakes on both sides, a registered
// result with NZCV flags, an illegal-opcode flag and an iterative multiplier
// that retires MUL_STEP multiplier bits per BUSY cycle.
module alu_hs #(
  parameter int N        = 64,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         illegal
);

  localparam int STEPS = N / MUL_STEP;
  localparam int CW    = $clog2(STEPS);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_illegal;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last_step;
  logic [N-1:0]     w_bop;
  logic [N:0]       w_sum;
  logic [N-1:0]     w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [2*N-1:0]   w_pp;
  logic [2*N-1:0]   w_acc_next;

  // Ready is held low while reset is asserted so nothing is taken mid-reset.
  assign in_ready    = reset && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (ALUControl == OP_MUL);
  assign w_last_step = (r_count == CW'(STEPS - 1));

  assign out_valid = (r_state == S_HOLD);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign negative  = r_result[N-1];
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

  // Single-cycle operations: SUB shares the adder as a + ~b + 1.
  always_comb begin
    w_bop = (ALUControl == OP_SUB) ? ~b : b;
    w_sum = {1'b0, a} + {1'b0, w_bop} + {{N{1'b0}}, (ALUControl == OP_SUB)};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (ALUControl)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD, OP_SUB: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (a[N-1] == w_bop[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      OP_PASS: w_res = b;
      OP_NOR:  w_res = ~(a | b);
      OP_MUL:  w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // Partial product for the low MUL_STEP multiplier bits, added into the accumulator.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
    w_acc_next = r_acc + w_pp;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; HOLD with out_ready behaves like IDLE for a new accept.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_is_mul ? S_BUSY : S_HOLD;
      S_BUSY: if (w_last_step) w_state_next = S_HOLD;
      S_HOLD: begin
        if (w_accept)       w_state_next = w_is_mul ? S_BUSY : S_HOLD;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result/flag registers and the iterative multiplier datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_count    <= '0;
    end else if (w_accept && w_is_mul) begin
      // Result outputs keep their previous value until the product is ready.
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_result   <= w_res;
      r_carry    <= w_c;
      r_overflow <= w_v;
      r_illegal  <= w_ill;
    end else if (r_state == S_BUSY) begin
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_acc    <= w_acc_next;
      r_count  <= r_count + 1'b1;
      if (w_last_step) begin
        r_result   <= w_acc_next[N-1:0];
        r_carry    <= 1'b0;
        r_overflow <= |w_acc_next[2*N-1:N];
        r_illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// Testbench for alu_hs: directed vector table, random ops against a
// behavioural model, backpressure, MUL_STEP=4 latency and mid-op reset.
module tb_alu_hs;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [3:0]   op = 4'b0;

  logic         in_ready, out_valid, zero, negative, carry, overflow, illegal;
  logic [N-1:0] result;
  logic         in_ready4, out_valid4, zero4, negative4, carry4, overflow4, illegal4;
  logic [N-1:0] result4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_hs #(.N(N), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  alu_hs #(.N(N), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .ALUControl(op), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .zero(zero4), .negative(negative4), .carry(carry4),
    .overflow(overflow4), .illegal(illegal4)
  );

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         v;
    logic         ill;
  } exp_t;

  typedef struct {
    logic [3:0]   o;
    logic [N-1:0] x;
    logic [N-1:0] y;
    exp_t         e;
  } vec_t;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, want);
    end
  endtask

  // Reference model from plain arithmetic on wide signed/unsigned values.
  function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t               e;
    logic [N:0]         s;
    logic signed [N:0]  ss;
    logic [2*N-1:0]     p;
    e = '0;
    case (o)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b0010: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[N-1:0];
        e.c = s[N];
        ss  = $signed({x[N-1], x}) + $signed({y[N-1], y});
        e.v = (ss[N] != ss[N-1]);
      end
      4'b0110: begin
        e.r = x - y;
        e.c = (x >= y);
        ss  = $signed({x[N-1], x}) - $signed({y[N-1], y});
        e.v = (ss[N] != ss[N-1]);
      end
      4'b0111: e.r = y;
      4'b1100: e.r = ~(x | y);
      4'b1000: begin
        p   = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        e.r = p[N-1:0];
        e.v = (p[2*N-1:N] != '0);
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check1("issue_ready", in_ready, 1'b1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency/outputs, then consumes the result.
  task automatic collect(input string nm, input exp_t e, input int lat);
    int cyc;
    int lo;
    cyc = 0; lo = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!in_ready) lo++;
    end while (!out_valid && cyc < 300);
    check({nm, ".lat"}, N'(cyc), N'(lat));
    check({nm, ".rdy_lo"}, N'(lo), N'(cyc));
    check({nm, ".res"}, result, e.r);
    check1({nm, ".z"}, zero, (e.r == '0));
    check1({nm, ".n"}, negative, e.r[N-1]);
    check1({nm, ".c"}, carry, e.c);
    check1({nm, ".v"}, overflow, e.v);
    check1({nm, ".ill"}, illegal, e.ill);
    $display("op=%b a=%h b=%h -> result=%h lat=%0d", op, a, b, result, cyc);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check1({nm, ".drain"}, out_valid, 1'b0);
    check({nm, ".keep"}, result, e.r);
  endtask

  function automatic int lat_of(input logic [3:0] o);
    return (o == 4'b1000) ? N + 1 : 1;
  endfunction

  vec_t vt[10];
  logic [3:0] opsel[9];

  initial begin
    exp_t e, e1, e2;
    logic [N-1:0] rx, ry;
    logic [3:0] ro;
    int cyc;

    vt[0] = '{4'b0000, 64'habcde, 64'hef8965, '{64'ha8844, 1'b0, 1'b0, 1'b0}};
    vt[1] = '{4'b0010, 64'h12345678, 64'h75abef, '{64'h12aa0267, 1'b0, 1'b0, 1'b0}};
    vt[2] = '{4'b0110, 64'h8000_0000_0000_0000, 64'h1, '{64'h7fff_ffff_ffff_ffff, 1'b1, 1'b1, 1'b0}};
    vt[3] = '{4'b0011, 64'h99999, 64'haaaa, '{64'h0, 1'b0, 1'b0, 1'b1}};
    vt[4] = '{4'b0111, 64'h0, 64'hbaba6767, '{64'hbaba6767, 1'b0, 1'b0, 1'b0}};
    vt[5] = '{4'b1000, 64'h12345, 64'h10, '{64'h123450, 1'b0, 1'b0, 1'b0}};
    vt[6] = '{4'b1000, 64'h1_0000_0000, 64'h1_0000_0000, '{64'h0, 1'b0, 1'b1, 1'b0}};
    vt[7] = '{4'b1100, 64'h0, 64'h0, '{64'hffff_ffff_ffff_ffff, 1'b0, 1'b0, 1'b0}};
    vt[8] = '{4'b0001, 64'hf0, 64'h0f, '{64'hff, 1'b0, 1'b0, 1'b0}};
    vt[9] = '{4'b0010, 64'hffff_ffff_ffff_ffff, 64'h1, '{64'h0, 1'b1, 1'b0, 1'b0}};
    opsel = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011, 4'b1111};

    // Reset state
    #1;
    check1("rst.out_valid", out_valid, 1'b0);
    check1("rst.in_ready", in_ready, 1'b0);
    check("rst.result", result, '0);
    check1("rst.zero", zero, 1'b1);
    check1("rst.flags", negative | carry | overflow | illegal, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].o, vt[i].x, vt[i].y);
      collect($sformatf("vec%0d", i), vt[i].e, lat_of(vt[i].o));
    end

    // Randomised ops against the model
    for (int i = 0; i < 30; i++) begin
      ro = opsel[$urandom_range(0, 8)];
      rx = {$urandom, $urandom};
      ry = (i % 3 == 0) ? N'($urandom_range(0, 255)) : {$urandom, $urandom};
      issue(ro, rx, ry);
      collect($sformatf("rnd%0d", i), model(ro, rx, ry), lat_of(ro));
    end

    // Backpressure with a waiting op, then back-to-back accept
    e1 = model(4'b0010, 64'h1111, 64'h2222);
    e2 = model(4'b0001, 64'h5000, 64'h0a0a);
    issue(4'b0010, 64'h1111, 64'h2222);
    @(negedge clk);
    check1("bp.valid", out_valid, 1'b1);
    op = 4'b0001; a = 64'h5000; b = 64'h0a0a; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check1($sformatf("bp.rdy%0d", k), in_ready, 1'b0);
      check($sformatf("bp.res%0d", k), result, e1.r);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check1("bp.rdy_up", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check1("bp.next_valid", out_valid, 1'b1);
    check("bp.next_res", result, e2.r);
    $display("backpressure: second result=%h", result);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // MUL_STEP=4 instance: 16 BUSY cycles, out_valid on cycle 17
    for (int i = 5; i < 7; i++) begin
      @(negedge clk);
      check1("m4.rdy", in_ready4, 1'b1);
      op = vt[i].o; a = vt[i].x; b = vt[i].y; in_valid4 = 1'b1;
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!out_valid4 && cyc < 300);
      check("m4.lat", N'(cyc), N'(17));
      check("m4.res", result4, vt[i].e.r);
      check1("m4.z", zero4, (vt[i].e.r == '0));
      check1("m4.v", overflow4, vt[i].e.v);
      $display("mul_step4 a=%h b=%h -> result=%h lat=%0d", a, b, result4, cyc);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
    end

    // Reset pulse in the middle of a multiply
    issue(4'b0111, 64'h0, 64'hbaba6767);
    collect("pre_rst", model(4'b0111, 64'h0, 64'hbaba6767), 1);
    issue(4'b1000, 64'h12345, 64'h10);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check1("mrst.out_valid", out_valid, 1'b0);
    check1("mrst.in_ready", in_ready, 1'b0);
    check("mrst.result", result, '0);
    check1("mrst.zero", zero, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check1("mrst.rdy_after", in_ready, 1'b1);
    check1("mrst.valid_after", out_valid, 1'b0);
    $display("reset pulse during MUL: result=%h", result);
    issue(4'b0010, 64'h7fff_ffff_ffff_ffff, 64'h1);
    collect("post_rst_add", model(4'b0010, 64'h7fff_ffff_ffff_ffff, 64'h1), 1);
    issue(4'b1000, 64'h3, 64'h5);
    collect("post_rst_mul", model(4'b1000, 64'h3, 64'h5), N + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
